e_mdu: RTL
==========

# e_mdu

- Multi-cycle multiply/divide unit in the Execute stage, next to the single-cycle ALU.
- Accepts `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` commands with a `start` pulse.
- Holds the architectural HI/LO registers and serves `mfhi`/`mflo` reads.
- Raises `busy` to the hazard unit while an operation is in flight; the hazard unit stalls any MDU instruction in D while `start | busy`.

## Interface
- `MULT_CYCLES`, 5, cycles from `start` to HI/LO update for mult/multu (≥1)
- `DIV_CYCLES`, 10, cycles from `start` to HI/LO update for div/divu (≥1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `start`  in  1  qualifies `MDUop` as a write/compute command this cycle
- `MDUop`  in  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mfhi, 0110 mflo, 0111 mthi, 1000 mtlo
- `srcA`  in  32  rs operand (dividend / multiplicand / mthi-mtlo data)
- `srcB`  in  32  rt operand (divisor / multiplier)
- `busy`  out  1  operation in flight
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `MDUout`  out  32  HI when `MDUop`=mfhi, LO when mflo, else 0 (combinational)

## Operation
- States: IDLE (counter=0), RUN (counter>0). `busy` = (counter != 0), registered.
- IDLE + `start` + mult/multu/div/divu:
  - compute the result from `srcA`/`srcB` sampled at that edge into pending registers;
  - load the counter with `MULT_CYCLES` or `DIV_CYCLES`;
  - go to RUN.
- RUN: decrement each edge. On the edge where the counter goes 1→0, commit the pending values to HI/LO and return to IDLE.
- mult: signed 32×32→64; HI = product[63:32], LO = product[31:0]. multu: same, unsigned.
- div: LO = signed quotient truncated toward zero, HI = remainder with sign of dividend. divu: unsigned.
- Divide by zero: the operation still takes `DIV_CYCLES` with `busy` asserted; HI/LO retain their prior values.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` + mthi (mtlo) while IDLE: HI (LO) ← `srcA` at that edge; `busy` stays 0.
- `start` with mfhi/mflo/none: no state change.
- Any `start` while RUN is ignored: no restart, no HI/LO write. Avoiding this is the hazard unit's job; the MDU guarantees the ignore.
- mfhi/mflo while RUN: `MDUout` returns the old (pre-commit) HI/LO.
- Reset (asynchronous, `reset`=0): HI=0, LO=0, counter=0, pending registers=0, `busy`=0 immediately. An in-flight operation is discarded, with no partial commit.

## Timing
- `start` sampled at edge t0 → `busy`=1 from just after t0 through edge t0+N (N = latency parameter).
- HI/LO show the new value and `busy`=0 after edge t0+N.
- Exactly N cycles of `busy` per accepted compute command.
- Back-to-back: a new `start` sampled at edge t0+N is accepted, since the counter reads 1 at that edge. Same-edge commit-then-accept is required: the old result commits and the new operands load at that edge.
- mthi/mtlo: zero latency; the value is visible on HI/LO after the sampling edge.
- `MDUout`: combinational from `MDUop` and the current HI/LO; no registered delay.

## Test plan
- Reset, then mult `srcA`=0xFFFFFFFF, `srcB`=2 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div `srcA`=0xFFFFFFF9 (−7), `srcB`=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 7/2 → LO=3, HI=1.
- divu x/0 with HI=LO=0x12345678 preloaded via mthi/mtlo → `busy` lasts 10 cycles; HI/LO unchanged at 0x12345678.
- During a div RUN:
  - assert `start` with mtlo 0xDEADBEEF → ignored: LO is not 0xDEADBEEF and the counter is not restarted;
  - mflo during RUN → `MDUout` = old LO.
- Back-to-back: mult 3×4, then `start` with mult 5×6 at the commit edge → LO=12 after 5 cycles, LO=30 after 10 cycles, `busy` continuously high.
- Drop `reset` in the 3rd cycle of a mult 3×4 with HI/LO previously nonzero → `busy`=0 and HI=LO=0 immediately. After release: no commit, and the next mthi 0xA5A5A5A5 is visible on HI after one edge.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed when a command is accepted, then committed after a fixed latency.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MFHI  = 4'b0101;
  localparam logic [3:0] OP_MFLO  = 4'b0110;
  localparam logic [3:0] OP_MTHI  = 4'b0111;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;

  logic        is_mul, is_div, is_signed;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        a_neg, b_neg, b_zero;
  logic [31:0] a_mag, b_mag, div_den, q_mag, r_mag, quot, rem;
  logic        accept_cmp, can_move;

  // Operation decode
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    case (MDUop)
      OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
      OP_MULTU: begin is_mul = 1'b1; is_signed = 1'b0; end
      OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  begin is_div = 1'b1; is_signed = 1'b0; end
      default:  begin is_mul = 1'b0; is_div = 1'b0; is_signed = 1'b0; end
    endcase
  end

  // Multiplier: the low 64 bits of the extended product serve both signednesses
  always_comb begin
    mul_a = {{32{is_signed & srcA[31]}}, srcA};
    mul_b = {{32{is_signed & srcB[31]}}, srcB};
    mul_p = mul_a * mul_b;
  end

  // Divider on magnitudes; signs restored afterwards (quotient toward zero, remainder follows dividend)
  always_comb begin
    a_neg   = is_signed & srcA[31];
    b_neg   = is_signed & srcB[31];
    a_mag   = a_neg ? (32'd0 - srcA) : srcA;
    b_mag   = b_neg ? (32'd0 - srcB) : srcB;
    b_zero  = (srcB == 32'd0);
    div_den = b_zero ? 32'd1 : b_mag;
    q_mag   = a_mag / div_den;
    r_mag   = a_mag % div_den;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Next-state: commit on the final count, then accept a new command on the same edge
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end

    accept_cmp = start & (is_mul | is_div) & (cnt_q <= CNT_ONE);
    can_move   = start & (cnt_q == CNT_ZERO);

    if (accept_cmp) begin
      if (is_mul) begin
        pend_hi_d = mul_p[63:32];
        pend_lo_d = mul_p[31:0];
        cnt_d     = CNT_MUL;
      end else if (b_zero) begin
        // divide by zero re-commits the current (post-commit) HI/LO, i.e. leaves them unchanged
        pend_hi_d = hi_d;
        pend_lo_d = lo_d;
        cnt_d     = CNT_DIV;
      end else begin
        pend_hi_d = rem;
        pend_lo_d = quot;
        cnt_d     = CNT_DIV;
      end
    end else if (can_move && (MDUop == OP_MTHI)) begin
      hi_d = srcA;
    end else if (can_move && (MDUop == OP_MTLO)) begin
      lo_d = srcA;
    end else begin
      pend_hi_d = pend_hi_d;
    end

    busy_d = (cnt_d != CNT_ZERO);
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= CNT_ZERO;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // Read port: current architectural HI/LO, no added latency
  always_comb begin
    case (MDUop)
      OP_MFHI: MDUout = hi_q;
      OP_MFLO: MDUout = lo_q;
      default: MDUout = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
